// File: rtl/bad_pixel_lut_writer.sv
// Bad-pixel LUT writer: collects sorted, de-duplicated coordinates per frame,
// writes them to the LUT, appends a sentinel and commits the entry count.
module bad_pixel_lut_writer #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_BIT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     det_valid,
  input  logic [WIDTH_BITS-1:0]    det_x,
  input  logic [HEIGHT_BITS-1:0]   det_y,
  output logic                     wen_lut,
  output logic [BAD_POINT_BIT-1:0] waddr_lut,
  output logic [31:0]              wdata_lut,
  output logic [BAD_POINT_BIT-1:0] bad_point_num,
  output logic                     table_done,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int KW = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [BAD_POINT_BIT-1:0] CAP = '1;
  localparam logic [BAD_POINT_BIT-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SENTINEL,
    COMMIT
  } state_t;

  state_t                   state;
  logic [BAD_POINT_BIT-1:0] cnt;
  logic [KW-1:0]            last_key;
  logic                     last_valid;

  logic [KW-1:0]            key;
  logic [31:0]              fmt;
  logic                     restart;
  logic [BAD_POINT_BIT-1:0] base_cnt;
  logic                     base_lv;
  logic                     base_ovf;
  logic [15:0]              base_drop;
  logic                     full;
  logic                     take;
  logic                     reject;
  logic [15:0]              drop_next;

  assign key = {det_y, det_x};
  assign fmt = {16'(det_y), 16'(det_x)};

  // Acceptance decision; a restart evaluates the detection against a fresh frame
  always_comb begin
    restart   = frame_start && enable;
    base_cnt  = restart ? '0 : cnt;
    base_lv   = restart ? 1'b0 : last_valid;
    base_ovf  = restart ? 1'b0 : overflow;
    base_drop = restart ? 16'd0 : drop_cnt;
    full      = (base_cnt == CAP);
    take      = det_valid && !full && (!base_lv || key > last_key);
    reject    = det_valid && !take;
    drop_next = base_drop;
    if (reject && base_drop != 16'hFFFF) drop_next = base_drop + 16'd1;
  end

  // Frame FSM with registered LUT write port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_key      <= '0;
      last_valid    <= 1'b0;
      wen_lut       <= 1'b0;
      waddr_lut     <= '0;
      wdata_lut     <= '0;
      bad_point_num <= '0;
      table_done    <= 1'b0;
      overflow      <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      wen_lut    <= 1'b0;
      table_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (restart) begin
            cnt        <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            last_valid <= 1'b0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          cnt        <= take ? base_cnt + ONE : base_cnt;
          last_valid <= take ? 1'b1 : base_lv;
          drop_cnt   <= drop_next;
          overflow   <= base_ovf | (det_valid && full);
          if (take) begin
            wen_lut   <= 1'b1;
            waddr_lut <= base_cnt;
            wdata_lut <= fmt;
            last_key  <= key;
          end
          if (frame_end && !restart) state <= SENTINEL;
        end
        SENTINEL: begin
          wen_lut   <= 1'b1;
          waddr_lut <= cnt;
          wdata_lut <= 32'hFFFF_FFFF;
          state     <= COMMIT;
        end
        COMMIT: begin
          bad_point_num <= cnt;
          table_done    <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
